// File: rtl/mem_loader.sv
// mem_loader: packs an 8-bit byte stream little-endian into dw-bit words and
// writes them to consecutive addresses from 0 over a ce/we/addr/di port.
// Optional trailing checksum byte: define MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
   parameter int unsigned aw = 10,
   parameter int unsigned dw = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [aw:0]   len,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          mem_ce,
   output logic          mem_we,
   output logic [aw-1:0] mem_addr,
   output logic [dw-1:0] mem_di,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned BYTES = dw / 8;
   localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [BCW-1:0] BYTE_ONE  = BCW'(1);
   localparam logic [aw:0]    CNT_ONE   = (aw + 1)'(1);
   localparam logic [aw-1:0]  ADDR_ONE  = aw'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   // State entered once all words are written (or immediately for len=0).
`ifdef MEM_LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHECK;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t          state_q;
   state_t          state_d;
   logic [aw:0]     len_q;
   logic [aw:0]     word_cnt;
   logic [BCW-1:0]  byte_cnt;
   logic [aw-1:0]   addr_q;
   logic [dw-1:0]   word_q;
   logic            accept;
   logic            last_word;
   logic            take_start;

   assign accept     = in_valid && in_ready;
   assign last_word  = ((word_cnt + CNT_ONE) == len_q);
   assign take_start = (state_q == S_IDLE) && start;

   // Outputs are pure decodes of registered state.
`ifdef MEM_LOADER_CHECKSUM_EN
   assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
   assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
   assign in_ready = (state_q == S_LOAD);
   assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
`endif
   assign mem_ce   = (state_q == S_WRITE);
   assign mem_we   = (state_q == S_WRITE);
   assign done     = (state_q == S_DONE);
   assign mem_addr = addr_q;
   assign mem_di   = word_q;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (len == '0) ? S_TAIL : S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept && (byte_cnt == LAST_BYTE)) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            state_d = last_word ? S_TAIL : S_LOAD;
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Word assembly, word/byte counters and write address.
   // The address only advances between words so it holds the last written
   // location after the load and never wraps when len = 1<<aw.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q    <= '0;
         word_cnt <= '0;
         byte_cnt <= '0;
         addr_q   <= '0;
         word_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_q    <= len;
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  addr_q   <= '0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  for (int unsigned i = 0; i < BYTES; i++) begin
                     if (byte_cnt == BCW'(i)) begin
                        word_q[8*i +: 8] <= in_data;
                     end
                  end
                  byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BYTE_ONE;
               end
            end
            S_WRITE: begin
               word_cnt <= word_cnt + CNT_ONE;
               if (!last_word) begin
                  addr_q <= addr_q + ADDR_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0] cks_q;
   logic [7:0] cks_sum;
   logic       err_q;

   assign cks_sum = cks_q + in_data;
   assign err     = err_q;

   // Running byte sum over data bytes; checksum byte resolves err.
   always_ff @(posedge clk) begin
      if (rst) begin
         cks_q <= '0;
         err_q <= 1'b0;
      end else if (take_start) begin
         cks_q <= '0;
         err_q <= 1'b0;
      end else if (accept) begin
         if (state_q == S_LOAD) begin
            cks_q <= cks_sum;
         end else begin
            err_q <= (cks_sum != 8'h00);
         end
      end
   end
`else
   assign err = 1'b0;
   logic unused_start;
   assign unused_start = take_start;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader (aw=4, dw=32). Honors
// MEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_mem_loader;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int BYTES = DW / 8;
`ifdef MEM_LOADER_CHECKSUM_EN
   localparam int CKS = 1;
`else
   localparam int CKS = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   len = '0;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          mem_ce;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_di;
   logic          busy;
   logic          done;
   logic          err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   mem_loader #(.aw(AW), .dw(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "/in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "/mem_ce"},   64'(mem_ce),   64'd0);
      check({tag, "/mem_we"},   64'(mem_we),   64'd0);
      check({tag, "/mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, "/mem_di"},   64'(mem_di),   64'd0);
      check({tag, "/busy"},     64'(busy),     64'd0);
      check({tag, "/done"},     64'(done),     64'd0);
      check({tag, "/err"},      64'(err),      64'd0);
   endtask

   // Runs one load from IDLE. Called and returns just after a negedge.
   // mode: 0 = in_valid always, 1 = every other cycle, 2 = random (also
   // random start/len noise while busy). rst_after >= 0 aborts with reset
   // once that many bytes have been accepted.
   task automatic load(input string name, input int nw, input logic [7:0] data[$],
                       input int mode, input bit bad, input int rst_after);
      logic [7:0]    stream[$];
      logic [DW-1:0] words[$];
      logic [DW-1:0] w;
      logic [7:0]    sum;
      logic [7:0]    cks;
      int bi, widx, exp_write, exp_done, act_done, t1, total, act_writes;
      bit v, rdy, finished, aborted;

      stream = data;
      sum = 8'h00;
      foreach (data[i]) sum = sum + data[i];
      for (int k = 0; k < nw; k++) begin
         w = '0;
         for (int j = 0; j < BYTES; j++) w = w | (DW'(data[k*BYTES + j]) << (8*j));
         words.push_back(w);
      end
      cks = 8'h00 - sum + {7'd0, bad};
      if (CKS != 0) stream.push_back(cks);
      total = nw * BYTES + CKS;

      start = 1'b1;
      len = (AW+1)'(nw);
      @(negedge clk);
      start = 1'b0;
      len = '0;
      t1 = cyc;
      bi = 0; widx = 0; exp_write = -1; act_done = -1; act_writes = 0;
      exp_done = (total == 0) ? t1 : -1;
      finished = 1'b0; aborted = 1'b0;
      check({name, "/err_cleared"}, 64'(err), 64'd0);

      for (int budget = 0; budget < 2000 && !finished; budget++) begin
         rdy = (cyc != exp_write) && (cyc != exp_done) && (bi < total);
         if (done === 1'b1 && act_done < 0) act_done = cyc;
         if (mem_ce === 1'b1) act_writes++;
         check({name, "/in_ready"}, 64'(in_ready), 64'(rdy));
         check({name, "/busy"},     64'(busy),     64'(cyc != exp_done));
         check({name, "/done"},     64'(done),     64'(cyc == exp_done));
         check({name, "/mem_ce"},   64'(mem_ce),   64'(cyc == exp_write));
         check({name, "/mem_we"},   64'(mem_we),   64'(cyc == exp_write));
         if (cyc == exp_write) begin
            check({name, "/addr"}, 64'(mem_addr), 64'(widx));
            check({name, "/data"}, 64'(mem_di),   64'(words[widx]));
            widx++;
            if (widx == nw && CKS == 0) exp_done = cyc + 1;
         end
         if (cyc == exp_done) begin
            check({name, "/err"},       64'(err),      64'((CKS != 0) && bad));
            check({name, "/addr_hold"}, 64'(mem_addr), 64'((nw > 0) ? nw - 1 : 0));
            finished = 1'b1;
            start = 1'b0;
            in_valid = 1'b0;
         end else begin
            case (mode)
               0: v = 1'b1;
               1: v = cyc[0];
               default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data = (bi < stream.size()) ? stream[bi] : 8'($urandom);
            if (mode == 2) begin
               start = 1'($urandom_range(0, 1));
               len = (AW+1)'($urandom_range(0, 16));
            end
            if (v && rdy) begin
               bi++;
               if (bi <= nw * BYTES && (bi % BYTES) == 0) exp_write = cyc + 1;
               if (bi == total && bi > nw * BYTES) exp_done = cyc + 1;
            end
            if (rst_after >= 0 && bi == rst_after) begin
               @(negedge clk);
               check({name, "/no_strobe"}, 64'(mem_ce), 64'd0);
               rst = 1'b1;
               in_valid = 1'b0;
               start = 1'b0;
               @(negedge clk);
               rst = 1'b0;
               check_reset_outputs({name, "/after_rst"});
               finished = 1'b1;
               aborted = 1'b1;
            end
         end
         if (!finished) @(negedge clk);
      end

      if (!finished) check({name, "/timeout"}, 64'd0, 64'd1);
      if (finished && !aborted) begin
         check({name, "/writes"}, 64'(act_writes), 64'(nw));
         if (mode == 0)
            check({name, "/latency"}, 64'(act_done - t1), 64'(nw * (BYTES + 1) + CKS));
         @(negedge clk);
         check({name, "/post_done"},  64'(done),     64'd0);
         check({name, "/post_busy"},  64'(busy),     64'd0);
         check({name, "/post_rdy"},   64'(in_ready), 64'd0);
         check({name, "/post_ce"},    64'(mem_ce),   64'd0);
         check({name, "/post_addr"},  64'(mem_addr), 64'((nw > 0) ? nw - 1 : 0));
         check({name, "/post_err"},   64'(err),      64'((CKS != 0) && bad));
      end
   endtask

   initial begin
      logic [7:0] d[$];
      int nw;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Stray bytes while idle must be ignored.
      in_valid = 1'b1;
      in_data = 8'hFF;
      repeat (3) begin
         @(negedge clk);
         check("idle/in_ready", 64'(in_ready), 64'd0);
         check("idle/busy",     64'(busy),     64'd0);
         check("idle/mem_ce",   64'(mem_ce),   64'd0);
      end
      in_valid = 1'b0;

      d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      load("b2b", 2, d, 0, 1'b0, -1);
      load("toggle", 2, d, 1, 1'b0, -1);

      d = '{8'h10, 8'h20, 8'h30, 8'h40};
      load("cks_ok", 1, d, 0, 1'b0, -1);
      load("cks_bad", 1, d, 0, 1'b1, -1);
      repeat (3) @(negedge clk);
      check("err_sticky", 64'(err), 64'(CKS));

      d.delete();
      load("len0", 0, d, 0, 1'b0, -1);

      d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      load("rst_mid", 2, d, 0, 1'b0, 7);
      d = '{8'h10, 8'h20, 8'h30, 8'h40};
      load("restart", 1, d, 0, 1'b0, -1);

      for (int r = 0; r < 5; r++) begin
         nw = $urandom_range(1, 6);
         d.delete();
         for (int i = 0; i < nw * BYTES; i++) d.push_back(8'($urandom));
         load("rand", nw, d, 2, 1'($urandom_range(0, 1)), -1);
      end

      d.delete();
      for (int i = 0; i < 16 * BYTES; i++) d.push_back(8'($urandom));
      load("full", 16, d, 0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
# mem_loader

Write-side companion of the synchronous single-port ROM/RAM used throughout the I2C controller support code: accepts a byte stream (e.g. bytes delivered by the I2C slave datapath or a test bench), packs it little-endian into `dw`-bit words and writes them to consecutive memory addresses starting at 0 over a `ce`/`we`/`addr`/`di` single-port write interface. It is used to load ROM/RAM images at run time instead of via `$readmemh`, and reports completion and (optionally) checksum errors.

## Interface
Parameters:
- `aw`, 10, address bits; memory depth is `1<<aw` words
- `dw`, 32, data bits; must be a multiple of 8, `BYTES = dw/8`

Ports (reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous reset, active high
- `start`  in  1  begin a load; sampled only in IDLE
- `len`  in  aw+1  number of words to load, 0..`1<<aw`; sampled with `start`
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `mem_ce`  out  1  memory chip enable (write strobe qualifier)
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  aw  write address
- `mem_di`  out  dw  write data
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  checksum error; sticky until next accepted `start`

## Operation
- States: IDLE, LOAD, WRITE, CHECK (only with checksum), DONE.
- IDLE: `start`=1 latches `len`, clears word counter, byte counter, address, checksum and `err`. If `len`=0 go to CHECK (macro on) or DONE; else LOAD.
- LOAD: `in_ready`=1. Byte accepted when `in_valid && in_ready`; byte n (0-based in the word) goes to `mem_di[8n+7:8n]`. After byte `BYTES-1` accepted, go to WRITE. Bytes not accepted are neither stored nor summed.
- WRITE: exactly one cycle, `mem_ce`=`mem_we`=1, `mem_addr` = word index, `mem_di` = assembled word; `in_ready`=0. Then address+1, word count+1; if count == `len` go to CHECK/DONE, else LOAD.
- CHECK: `in_ready`=1; next accepted byte is the checksum. `err` set if (sum of all data bytes + checksum byte) mod 256 ≠ 0. Go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0; return to IDLE.
- `busy`=1 in LOAD, WRITE, CHECK; 0 in IDLE, DONE.
- `start` while not in IDLE is ignored. Address never wraps (`len` ≤ `1<<aw`); `mem_addr` is held at its last value after the load.
- `rst` in any state: return to IDLE in the next cycle, no write strobe issued, partial word discarded.

## Timing
- Reset values: `in_ready`=0, `mem_ce`=0, `mem_we`=0, `mem_addr`=0, `mem_di`=0, `busy`=0, `done`=0, `err`=0. All outputs registered or decoded from state registers only; no combinational path from inputs to outputs.
- `start` sampled at edge t: `busy`=1 and `in_ready`=1 from cycle t+1.
- Last byte of a word accepted at edge k: write strobe in cycle k+1; `in_ready` returns in cycle k+2. Minimum cost per word = `BYTES`+1 cycles (one bubble).
- Last write in cycle w (macro off): `done` in cycle w+1. Macro on: `done` in the cycle after checksum acceptance, with `err` valid in the same cycle.
- `len`=0, macro off: `done` in cycle t+1, no write strobe.

## Configuration
- `MEM_LOADER_CHECKSUM_EN` defined: CHECK state present; one trailing checksum byte is consumed after the last word (also when `len`=0); `err` reflects the result.
- Not defined: no CHECK state, no checksum register; no trailing byte consumed; `err` tied to 0.

## Test plan
- Reset then idle: all outputs 0; `in_valid`=1 with `in_ready`=0 is ignored.
- `aw`=4, `dw`=32, `len`=2, bytes 01 02 03 04 05 06 07 08 back-to-back -> writes addr 0 data 0x04030201, addr 1 data 0x08070605, one bubble between words, `done` one cycle after second write.
- Same stream with `in_valid` toggled every other cycle -> identical writes, only non-valid cycles stretch timing.
- Macro on, `len`=1, bytes 10 20 30 40 then 0x60 -> write 0x40302010, `done`=1 `err`=0; repeat with checksum 0x61 -> `err`=1, held until next `start`.
- `len`=0, macro off -> `done` in cycle after `start`, `mem_ce`=0 throughout.
- `rst` asserted after 3 of 4 bytes of word 1 -> no write strobe, IDLE next cycle; fresh `start` restarts at addr 0.
